multdiv_iter: RTL and testbench

- Parametrised, multi-cycle signed multiply/divide unit. It sits beside the single-cycle `alu` in the execute stage.
- Replaces combinational mult/div paths with an iterative datapath:
  - radix-2 shift-add multiplier;
  - restoring divider.
- A start pulse launches an operation. A one-cycle ready pulse returns the result.
- The pipeline stalls on `busy`.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_iter_cond_negate.sv | 14 +
 rtl/multdiv_iter.sv | 156 +++++++++++++++
 tb/tb_multdiv_iter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Most-negative two's complement value of the given width (width <= 64).
    function automatic logic [63:0] most_neg(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/multdiv_iter_cond_negate.sv
// Conditional two's-complement negation: data_out = neg ? -data_in : data_in.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             neg,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = neg ? (~data_in + WIDTH'(1)) : data_in;
    end

endmodule

// File: rtl/multdiv_iter.sv
// Multi-cycle signed multiply (radix-2 shift-add) / divide (restoring) unit.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    import multdiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = WIDTH'(most_neg(WIDTH));

    state_t state, next_state;

    logic                 start;
    logic [WIDTH-1:0]     mag_a, mag_b, signed_res;
    logic [2*WIDTH-1:0]   acc, acc_next;
    logic [WIDTH-1:0]     rem, rem_next;
    logic [WIDTH-1:0]     operand_q;
    op_t                  op_q;
    logic                 sign_q, div_zero_q;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       add_sum, shifted, trial;
    logic [WIDTH-1:0]     prod_hi;
    logic [WIDTH-1:0]     res_next;
    logic                 exc_next;

    cond_negate #(.WIDTH(WIDTH)) u_neg_a (
        .data_in  (data_operandA),
        .neg      (data_operandA[WIDTH-1]),
        .data_out (mag_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_neg_b (
        .data_in  (data_operandB),
        .neg      (data_operandB[WIDTH-1]),
        .data_out (mag_b)
    );

    cond_negate #(.WIDTH(WIDTH)) u_neg_res (
        .data_in  (acc[WIDTH-1:0]),
        .neg      (sign_q),
        .data_out (signed_res)
    );

    always_comb begin
        start = ctrl_MULT ^ ctrl_DIV;
        busy  = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == LAST_ITER) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Both ops share acc: multiply keeps {partial product, multiplier}; divide
    // keeps the dividend in the low half, shifting quotient bits in behind it.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_q} : '0);
        shifted  = {rem, acc[WIDTH-1]};
        trial    = shifted - {1'b0, operand_q};
        acc_next = acc;
        rem_next = rem;
        if (op_q == OP_MULT) begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Overflow from the unsigned magnitude: a negative result may reach 2^(W-1).
    always_comb begin
        prod_hi  = acc[2*WIDTH-1:WIDTH];
        res_next = signed_res;
        exc_next = 1'b0;
        if (op_q == OP_MULT) begin
            if (sign_q) exc_next = (|prod_hi) || (acc[WIDTH-1] && (|acc[WIDTH-2:0]));
            else        exc_next = (|prod_hi) || acc[WIDTH-1];
        end else if (div_zero_q) begin
            res_next = '0;
            exc_next = 1'b1;
        end else begin
            exc_next = !sign_q && (acc[WIDTH-1:0] == MOST_NEG);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc            <= '0;
            rem            <= '0;
            operand_q      <= '0;
            op_q           <= OP_MULT;
            sign_q         <= 1'b0;
            div_zero_q     <= 1'b0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= ctrl_DIV ? OP_DIV : OP_MULT;
                        sign_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero_q <= (data_operandB == '0);
                        cnt        <= '0;
                        rem        <= '0;
                        if (ctrl_DIV) begin
                            operand_q <= mag_b;
                            acc       <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            operand_q <= mag_a;
                            acc       <= {{WIDTH{1'b0}}, mag_b};
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    data_result    <= res_next;
                    data_exception <= exc_next;
                    data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Randomized and directed checks of multdiv_iter (WIDTH=32 and WIDTH=8) against an arithmetic model.
module tb_multdiv_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a32, b32, res32;
    logic        m32, d32, exc32, rdy32, busy32;
    logic [7:0]  a8, b8, res8;
    logic        m8, d8, exc8, rdy8, busy8;

    int total = 0;
    int bad   = 0;
    bit cur8  = 1'b0;

    logic [31:0] res_s;
    logic        exc_s, rdy_s, busy_s;

    always #5 clock = ~clock;

    multdiv_iter #(.WIDTH(32)) dut32 (
        .clock (clock), .reset (reset),
        .data_operandA (a32), .data_operandB (b32),
        .ctrl_MULT (m32), .ctrl_DIV (d32),
        .data_result (res32), .data_exception (exc32),
        .data_resultRDY (rdy32), .busy (busy32)
    );

    multdiv_iter #(.WIDTH(8)) dut8 (
        .clock (clock), .reset (reset),
        .data_operandA (a8), .data_operandB (b8),
        .ctrl_MULT (m8), .ctrl_DIV (d8),
        .data_result (res8), .data_exception (exc8),
        .data_resultRDY (rdy8), .busy (busy8)
    );

    always_comb begin
        res_s  = cur8 ? {24'b0, res8} : res32;
        exc_s  = cur8 ? exc8  : exc32;
        rdy_s  = cur8 ? rdy8  : rdy32;
        busy_s = cur8 ? busy8 : busy32;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Signed arithmetic model of the unit.
    function automatic void ref_model(input int w, input bit d, input longint a, input longint b,
                                      output longint r, output bit e);
        longint mn, p;
        mn = -(longint'(1) <<< (w - 1));
        if (!d) begin
            p = a * b;
            r = sx(p, w);
            e = (p != r);
        end else if (b == 0) begin
            r = 0; e = 1'b1;
        end else if (a == mn && b == -1) begin
            r = mn; e = 1'b1;
        end else begin
            r = a / b; e = 1'b0;
        end
    endfunction

    task automatic launch(input bit d, input logic [31:0] a, input logic [31:0] b);
        if (cur8) begin a8 = a[7:0]; b8 = b[7:0]; m8 = !d; d8 = d; end
        else      begin a32 = a; b32 = b; m32 = !d; d32 = d; end
        @(posedge clock); #1;
        m32 = 1'b0; d32 = 1'b0; m8 = 1'b0; d8 = 1'b0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic collect(input int n0, input bit d, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        int n, w;
        bit busy_ok;
        longint r;
        bit e;
        logic [63:0] mask;
        w = cur8 ? 8 : 32;
        mask = (64'd1 << w) - 1;
        ref_model(w, d, sx(longint'(a), w), sx(longint'(b), w), r, e);
        n = n0; busy_ok = 1'b1;
        while (n < 100) begin
            @(posedge clock); #1;
            n++;
            if (rdy_s) break;
            if (!busy_s) busy_ok = 1'b0;
        end
        check({tag, "_lat"},  64'(n), 64'(w + 1));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_res"},  64'(res_s), 64'(r) & mask);
        check({tag, "_exc"},  64'(exc_s), 64'(e));
    endtask

    task automatic do_op(input bit d, input logic [31:0] a, input logic [31:0] b, input string tag);
        launch(d, a, b);
        collect(0, d, a, b, tag);
        @(posedge clock); #1;
        check({tag, "_rdy1"}, 64'(rdy_s), 64'd0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom % 6)
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w - 1);
            3: v = ($urandom % 2) ? 32'($urandom_range(0, 20)) : -32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int cnt;
        reset = 1'b1;
        a32 = '0; b32 = '0; m32 = 1'b0; d32 = 1'b0;
        a8  = '0; b8  = '0; m8  = 1'b0; d8  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_res32",  64'(res32),  64'd0);
        check("rst_exc32",  64'(exc32),  64'd0);
        check("rst_rdy32",  64'(rdy32),  64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_busy8",  64'(busy8),  64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        cur8 = 1'b0;
        do_op(1'b0, 32'd7, -32'd3, "mul_7x-3");
        do_op(1'b0, 32'd65536, 32'd65536, "mul_ovf");
        do_op(1'b1, -32'd7, 32'd2, "div_-7/2");
        do_op(1'b1, 32'd5, 32'd0, "div_by0");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

        // DIV pulse while busy must be ignored; a start in the RDY cycle is accepted.
        launch(1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clock);
        #1; d32 = 1'b1; a32 = 32'd100; b32 = 32'd5;
        @(posedge clock); #1; d32 = 1'b0;
        collect(10, 1'b0, 32'd6, 32'd7, "ignore");
        launch(1'b0, 32'd3, 32'd5);
        collect(0, 1'b0, 32'd3, 32'd5, "b2b");
        @(posedge clock); #1;
        check("b2b_rdy1", 64'(rdy32), 64'd0);

        // Reset mid-divide aborts without a ready pulse.
        launch(1'b1, 32'd100, 32'd7);
        repeat (14) @(posedge clock);
        #1; reset = 1'b1;
        @(posedge clock); #1;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_rdy",  64'(rdy32),  64'd0);
        check("abort_res",  64'(res32),  64'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (rdy32 || busy32) cnt++;
        end
        check("abort_quiet", 64'(cnt), 64'd0);

        m32 = 1'b1; d32 = 1'b1; a32 = 32'd3; b32 = 32'd4;
        @(posedge clock); #1;
        m32 = 1'b0; d32 = 1'b0;
        check("both_busy", 64'(busy32), 64'd0);
        cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (rdy32 || busy32) cnt++;
        end
        check("both_quiet", 64'(cnt), 64'd0);

        for (int i = 0; i < 30; i++) begin
            bit dv;
            dv = 1'($urandom);
            do_op(dv, pick(32), pick(32), dv ? "rnd32_div" : "rnd32_mul");
        end

        cur8 = 1'b1;
        do_op(1'b0, 32'h80, 32'hFF, "w8_mul_ovf");
        do_op(1'b1, 32'd100, 32'd7, "w8_div");
        for (int i = 0; i < 20; i++) begin
            bit dv;
            dv = 1'($urandom);
            do_op(dv, pick(8), pick(8), dv ? "rnd8_div" : "rnd8_mul");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
